alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station feeding the ALU: holds up to ENTRIES decoded ALU instructions, snoops the common data bus (CDB) for tagged results that resolve pending source operands, and issues one fully-ready instruction per cycle to the ALU. It is the consumer end of the CDB protocol the ALU drives. Decoder writes in, ALU reads out, CDB wakes entries up.

## Interface
- ENTRIES, 8: number of station slots (power of two, 2..16)
- DATA_W, 32: operand/result width
- TAG_W, 4: ROB tag width; tag value 0 means "no tag / value present"
- OP_W, 5: opcode width; opcode 0 is NOP

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- CDBTag  in  TAG_W  broadcast result tag; 0 = no broadcast this cycle
- CDBData  in  DATA_W  broadcast result value, valid when CDBTag != 0
- dispValid  in  1  decoder presents an instruction this cycle
- dispOp  in  OP_W  opcode
- dispValO  in  DATA_W  operand O value (meaningful when dispTagO == 0)
- dispTagO  in  TAG_W  producer tag of operand O, 0 if already available
- dispValT  in  DATA_W  operand T value
- dispTagT  in  TAG_W  producer tag of operand T
- dispDest  in  TAG_W  ROB tag the result will carry
- full  out  1  no free slot; decoder must not dispatch
- operandO  out  DATA_W  issued operand O
- operandT  out  DATA_W  issued operand T
- wrtTag  out  TAG_W  issued destination tag
- opCode  out  OP_W  issued opcode; NOP when nothing issued

## Operation
- Per slot: busy, op, valO, tagO, valT, tagT, dest. Operand ready when its tag == 0.
- Dispatch: if dispValid && !full, write into lowest-index non-busy slot, set busy. If dispValid && full, instruction is dropped (protocol violation; bench flags it).
- Dispatch bypass: if CDBTag != 0 and equals dispTagO (resp. dispTagT) in the same cycle, store CDBData and tag 0 for that operand.
- Wakeup: each cycle with CDBTag != 0, every busy slot whose tagO (tagT) equals CDBTag latches CDBData into valO (valT) and clears the tag. Both operands of one slot may wake on the same broadcast.
- Select: among busy slots with both tags 0 (registered state, before this edge's wakeup), pick lowest index; drive its fields to the output registers and clear busy. If none, opCode <= NOP, wrtTag <= 0, operands <= 0.
- Exactly one issue per cycle max; exactly one dispatch per cycle max.
- A slot freed by issue at edge k is allocatable for a dispatch sampled at edge k+1, not k.
- full = all slots busy (combinational from registered busy vector).
- Tag 0 on the CDB never matches anything, including waiting tags (waiting tags are never 0).

## Timing
- Reset (rst low, asynchronous): all busy cleared, opCode = NOP, wrtTag = 0, operandO = operandT = 0, full = 0. Release is synchronous to next clk edge; no dispatch accepted on that edge if rst still low.
- Dispatch with both operands ready, sampled at edge k: issued on outputs after edge k+1 (1-cycle latency), assuming no older ready slot at lower index.
- Operand woken by CDB at edge k: slot eligible for select at edge k+1, outputs valid after k+1.
- Dispatch bypass at edge k: same as ready-at-dispatch, issued after edge k+1.
- Outputs are registered; they hold one cycle then return to NOP unless another issue occurs.
- Reset asserted mid-operation discards all held instructions immediately.

## Test plan
- Reset: drive rst low with 3 busy slots -> outputs NOP/0, full=0 immediately; after release, first dispatch lands in slot 0.
- Ready dispatch: dispOp=ADD, valO=5, valT=7, tags 0, dest=3 at edge k -> after k+1 opCode=ADD, operandO=5, operandT=7, wrtTag=3; next cycle NOP.
- Wakeup: dispatch tagO=4, valT=2; hold 3 cycles (NOP out); CDBTag=4, CDBData=0x10 at edge m -> issue after m+1 with operandO=0x10, operandT=2.
- Bypass: dispatch tagO=6 with CDBTag=6, CDBData=9 on same edge -> issued next edge with operandO=9.
- Full/ordering: dispatch 8 unready instructions (tags 1..8 in both operands) -> full=1; extra dispatch ignored; broadcast tag 8 then 1 on consecutive edges -> slot 7 issues first, then slot 0; full drops after first issue.
- Double wakeup: slot with tagO=tagT=5, CDB tag 5 data 0x22 -> both operands 0x22 on issue.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the ALU.
// Holds up to ENTRIES decoded ALU instructions, snoops the CDB to resolve
// pending source operands, and issues at most one fully-ready instruction
// per cycle (lowest slot index first).
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   CDBTag, CDBData              result broadcast (tag 0 = no broadcast)
//   dispValid, dispOp, dispValO, dispTagO, dispValT, dispTagT, dispDest
//                                dispatch from the decoder
//   full                         all slots busy (combinational)
//   operandO, operandT, wrtTag, opCode
//                                registered issue to the ALU (NOP when idle)
module alu_rs #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OP_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  CDBTag,
  input  logic [DATA_W-1:0] CDBData,
  input  logic              dispValid,
  input  logic [OP_W-1:0]   dispOp,
  input  logic [DATA_W-1:0] dispValO,
  input  logic [TAG_W-1:0]  dispTagO,
  input  logic [DATA_W-1:0] dispValT,
  input  logic [TAG_W-1:0]  dispTagT,
  input  logic [TAG_W-1:0]  dispDest,
  output logic              full,
  output logic [DATA_W-1:0] operandO,
  output logic [DATA_W-1:0] operandT,
  output logic [TAG_W-1:0]  wrtTag,
  output logic [OP_W-1:0]   opCode
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] val_o;
    logic [TAG_W-1:0]  tag_o;
    logic [DATA_W-1:0] val_t;
    logic [TAG_W-1:0]  tag_t;
    logic [TAG_W-1:0]  dest;
  } slot_t;

  logic [ENTRIES-1:0] busy_q, busy_d;
  slot_t              slot_q [ENTRIES];
  slot_t              slot_d [ENTRIES];

  logic [OP_W-1:0]    op_code_q, op_code_d;
  logic [TAG_W-1:0]   wrt_tag_q, wrt_tag_d;
  logic [DATA_W-1:0]  operand_o_q, operand_o_d;
  logic [DATA_W-1:0]  operand_t_q, operand_t_d;

  logic               cdb_valid_c;
  logic [ENTRIES-1:0] ready_c;
  logic               issue_c;
  logic [IDX_W-1:0]   issue_idx_c;
  logic [IDX_W-1:0]   alloc_idx_c;
  logic               accept_c;

  assign full        = &busy_q;
  assign cdb_valid_c = (CDBTag != '0);
  assign accept_c    = dispValid && !full;

  // Select: lowest-index busy slot whose operands are both present (pre-wakeup state)
  always_comb begin
    issue_c     = 1'b0;
    issue_idx_c = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      ready_c[i] = busy_q[i] && (slot_q[i].tag_o == '0) && (slot_q[i].tag_t == '0);
    end
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (ready_c[i]) begin
        issue_c     = 1'b1;
        issue_idx_c = IDX_W'(i);
      end
    end
  end

  // Allocate: lowest-index free slot from registered busy, so a slot freed this edge is not reused
  always_comb begin
    alloc_idx_c = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx_c = IDX_W'(i);
    end
  end

  // Next state: issue, CDB wakeup, dispatch with same-cycle bypass
  always_comb begin
    busy_d      = busy_q;
    slot_d      = slot_q;
    op_code_d   = '0;
    wrt_tag_d   = '0;
    operand_o_d = '0;
    operand_t_d = '0;

    if (issue_c) begin
      op_code_d           = slot_q[issue_idx_c].op;
      wrt_tag_d           = slot_q[issue_idx_c].dest;
      operand_o_d         = slot_q[issue_idx_c].val_o;
      operand_t_d         = slot_q[issue_idx_c].val_t;
      busy_d[issue_idx_c] = 1'b0;
    end

    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (busy_q[i] && cdb_valid_c) begin
        if (slot_q[i].tag_o == CDBTag) begin
          slot_d[i].val_o = CDBData;
          slot_d[i].tag_o = '0;
        end
        if (slot_q[i].tag_t == CDBTag) begin
          slot_d[i].val_t = CDBData;
          slot_d[i].tag_t = '0;
        end
      end
    end

    if (accept_c) begin
      busy_d[alloc_idx_c]      = 1'b1;
      slot_d[alloc_idx_c].op   = dispOp;
      slot_d[alloc_idx_c].dest = dispDest;
      if (cdb_valid_c && (dispTagO == CDBTag)) begin
        slot_d[alloc_idx_c].val_o = CDBData;
        slot_d[alloc_idx_c].tag_o = '0;
      end else begin
        slot_d[alloc_idx_c].val_o = dispValO;
        slot_d[alloc_idx_c].tag_o = dispTagO;
      end
      if (cdb_valid_c && (dispTagT == CDBTag)) begin
        slot_d[alloc_idx_c].val_t = CDBData;
        slot_d[alloc_idx_c].tag_t = '0;
      end else begin
        slot_d[alloc_idx_c].val_t = dispValT;
        slot_d[alloc_idx_c].tag_t = dispTagT;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      op_code_q   <= '0;
      wrt_tag_q   <= '0;
      operand_o_q <= '0;
      operand_t_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      op_code_q   <= op_code_d;
      wrt_tag_q   <= wrt_tag_d;
      operand_o_q <= operand_o_d;
      operand_t_q <= operand_t_d;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign opCode   = op_code_q;
  assign wrtTag   = wrt_tag_q;
  assign operandO = operand_o_q;
  assign operandT = operand_t_q;

endmodule

// File: tb/tb_alu_rs.sv
// Testbench for alu_rs: directed scenarios followed by random traffic,
// all checked against a slot-level behavioural model of the station.
module tb_alu_rs;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [TW-1:0] CDBTag = '0;
  logic [DW-1:0] CDBData = '0;
  logic          dispValid = 1'b0;
  logic [OW-1:0] dispOp = '0;
  logic [DW-1:0] dispValO = '0;
  logic [TW-1:0] dispTagO = '0;
  logic [DW-1:0] dispValT = '0;
  logic [TW-1:0] dispTagT = '0;
  logic [TW-1:0] dispDest = '0;
  logic          full;
  logic [DW-1:0] operandO;
  logic [DW-1:0] operandT;
  logic [TW-1:0] wrtTag;
  logic [OW-1:0] opCode;

  alu_rs #(.ENTRIES(N), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .CDBTag(CDBTag), .CDBData(CDBData),
    .dispValid(dispValid), .dispOp(dispOp),
    .dispValO(dispValO), .dispTagO(dispTagO),
    .dispValT(dispValT), .dispTagT(dispTagT),
    .dispDest(dispDest),
    .full(full), .operandO(operandO), .operandT(operandT),
    .wrtTag(wrtTag), .opCode(opCode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: one record per slot, plus the expected issue outputs
  bit          m_busy [N];
  int unsigned m_op [N];
  int unsigned m_vo [N];
  int unsigned m_to [N];
  int unsigned m_vt [N];
  int unsigned m_tt [N];
  int unsigned m_dest [N];
  int unsigned e_op, e_tag, e_o, e_t;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < N; i++) if (!m_busy[i]) f = 1'b0;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    e_op = 0; e_tag = 0; e_o = 0; e_t = 0;
  endtask

  // One rising edge: oldest-index ready instruction goes out, broadcast resolves
  // waiting operands, new instruction takes the first slot that was free before the edge.
  task automatic model_edge();
    int sel = -1;
    int slot = -1;
    int unsigned ct = int'(CDBTag);
    bit was_full = m_full();
    for (int i = 0; i < N; i++) begin
      if (slot < 0 && !m_busy[i]) slot = i;
      if (sel < 0 && m_busy[i] && m_to[i] == 0 && m_tt[i] == 0) sel = i;
    end
    if (sel >= 0) begin
      e_op = m_op[sel]; e_tag = m_dest[sel]; e_o = m_vo[sel]; e_t = m_vt[sel];
    end else begin
      e_op = 0; e_tag = 0; e_o = 0; e_t = 0;
    end
    if (ct != 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && m_to[i] == ct) begin m_vo[i] = CDBData; m_to[i] = 0; end
        if (m_busy[i] && m_tt[i] == ct) begin m_vt[i] = CDBData; m_tt[i] = 0; end
      end
    end
    if (sel >= 0) m_busy[sel] = 1'b0;
    if (dispValid && !was_full) begin
      m_busy[slot] = 1'b1;
      m_op[slot]   = dispOp;
      m_dest[slot] = dispDest;
      if (ct != 0 && int'(dispTagO) == ct) begin m_vo[slot] = CDBData; m_to[slot] = 0; end
      else begin m_vo[slot] = dispValO; m_to[slot] = dispTagO; end
      if (ct != 0 && int'(dispTagT) == ct) begin m_vt[slot] = CDBData; m_tt[slot] = 0; end
      else begin m_vt[slot] = dispValT; m_tt[slot] = dispTagT; end
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".opCode"},   32'(opCode),   32'(e_op));
    chk({where, ".wrtTag"},   32'(wrtTag),   32'(e_tag));
    chk({where, ".operandO"}, operandO,      e_o);
    chk({where, ".operandT"}, operandT,      e_t);
    chk({where, ".full"},     32'(full),     32'(m_full()));
  endtask

  task automatic tick(input string where);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(where);
  endtask

  task automatic disp(input int unsigned op, input int unsigned vo, input int unsigned to,
                      input int unsigned vt, input int unsigned tt, input int unsigned dest);
    dispValid = 1'b1; dispOp = OW'(op);
    dispValO = vo; dispTagO = TW'(to);
    dispValT = vt; dispTagT = TW'(tt);
    dispDest = TW'(dest);
  endtask

  task automatic idle();
    dispValid = 1'b0; dispOp = '0; dispValO = '0; dispTagO = '0;
    dispValT = '0; dispTagT = '0; dispDest = '0;
  endtask

  task automatic cdb(input int unsigned tag, input int unsigned data);
    CDBTag = TW'(tag); CDBData = data;
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;
    tick("post_reset_idle");

    // Ready dispatch: ADD 5,7 -> dest 3
    disp(1, 5, 0, 7, 0, 3);
    tick("ready_disp");
    chk("ready_disp.nop", 32'(opCode), 32'd0);
    idle();
    tick("ready_issue");
    chk("ready.op", 32'(opCode), 32'd1);
    chk("ready.o", operandO, 32'd5);
    chk("ready.t", operandT, 32'd7);
    chk("ready.dest", 32'(wrtTag), 32'd3);
    tick("ready_after");
    chk("ready_after.nop", 32'(opCode), 32'd0);

    // Wakeup via CDB
    disp(2, 32'hdead, 4, 2, 0, 5);
    tick("wake_disp");
    idle();
    repeat (3) tick("wake_hold");
    chk("wake_hold.nop", 32'(opCode), 32'd0);
    cdb(4, 32'h10);
    tick("wake_cdb");
    cdb(0, 0);
    tick("wake_issue");
    chk("wake.o", operandO, 32'h10);
    chk("wake.t", operandT, 32'd2);
    chk("wake.dest", 32'(wrtTag), 32'd5);

    // Same-cycle bypass at dispatch
    disp(3, 0, 6, 1, 0, 7);
    cdb(6, 9);
    tick("byp_disp");
    idle(); cdb(0, 0);
    tick("byp_issue");
    chk("byp.o", operandO, 32'd9);
    chk("byp.op", 32'(opCode), 32'd3);

    // Fill all slots with waiting instructions
    for (int k = 1; k <= N; k++) begin
      disp(4, 0, k, 0, k, k);
      tick("fill");
    end
    idle();
    chk("fill.full", 32'(full), 32'd1);
    disp(5, 1, 0, 1, 0, 9);
    tick("fill_drop");
    idle();
    cdb(8, 32'h80);
    tick("order_wake8");
    cdb(1, 32'h11);
    tick("order_issue8");
    chk("order.first", 32'(wrtTag), 32'd8);
    chk("order.full_drop", 32'(full), 32'd0);
    cdb(0, 0);
    tick("order_issue1");
    chk("order.second", 32'(wrtTag), 32'd1);
    for (int k = 2; k < N; k++) begin
      cdb(k, k * 3);
      tick("drain");
    end
    cdb(0, 0);
    repeat (3) tick("drain_tail");
    chk("drain.empty", 32'(opCode), 32'd0);

    // Double wakeup from one broadcast
    disp(6, 0, 5, 0, 5, 10);
    tick("dbl_disp");
    idle();
    cdb(5, 32'h22);
    tick("dbl_cdb");
    cdb(0, 0);
    tick("dbl_issue");
    chk("dbl.o", operandO, 32'h22);
    chk("dbl.t", operandT, 32'h22);

    // Asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) begin
      disp(7, 0, 11 + k, 0, 0, k + 1);
      tick("mid_fill");
    end
    disp(8, 32'h55, 0, 32'h66, 0, 14);
    tick("mid_ready");
    idle();
    tick("mid_issue");
    chk("mid.issue_op", 32'(opCode), 32'd8);
    disp(9, 1, 0, 1, 0, 2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_outputs("rst_hold");
    idle();
    rst = 1'b1;
    disp(10, 32'haa, 0, 32'hbb, 0, 12);
    tick("rel_disp");
    idle();
    tick("rel_issue");
    chk("rel.op", 32'(opCode), 32'd10);
    chk("rel.o", operandO, 32'haa);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 1) == 0) cdb(0, 0);
      else cdb($urandom_range(1, 7), $urandom);
      if ((!m_full() && $urandom_range(0, 99) < 55) || $urandom_range(0, 99) < 3) begin
        disp($urandom_range(1, 31), $urandom,
             ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7),
             $urandom,
             ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7),
             $urandom_range(1, 15));
      end else begin
        idle();
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
